// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and bit-timing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Mid-bit offset in clocks for a given bit period.
    function automatic int unsigned half_bit(input int unsigned cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Byte-stream holding-register interface of the UART receiver.
interface uart_rx_ovs_if;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       ovr_clr;

    modport master (
        output data_out, valid, frame_err, parity_err, overrun,
        input  ready, ovr_clr
    );

    modport slave (
        input  data_out, valid, frame_err, parity_err, overrun,
        output ready, ovr_clr
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pad plus a history flop for edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic r_s1;
    logic r_s2;
    logic r_hist;

    // Flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_s1   <= rx;
            r_s2   <= r_s1;
            r_hist <= r_s2;
        end
    end

    assign rx_s = r_s2;
    // Needs history at 1, so a line held low must rise before re-arming.
    assign fall = r_hist & ~r_s2;
endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver: mid-bit 3-sample majority, optional parity, valid/ready holding register.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned PARITY       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    output logic          busy,
    uart_rx_ovs_if.master bus
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = half_bit(CLKS_PER_BIT);

    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntS0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CntS1   = CW'(HALF);
    localparam logic [CW-1:0] CntDec  = CW'(HALF + 1);

    uart_state_e   r_state;
    uart_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [1:0]    r_smp;
    logic          r_par_err;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_perr;
    logic          r_ovr;

    logic w_rx;
    logic w_fall;
    logic w_end;
    logic w_dec;
    logic w_maj;
    logic w_par_exp;
    logic w_done;
    logic w_take;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (w_rx),
        .fall  (w_fall)
    );

    assign w_end     = (r_cnt == CntLast);
    assign w_dec     = (r_cnt == CntDec);
    assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx) | (r_smp[1] & w_rx);
    assign w_par_exp = (PARITY == PARITY_ODD) ? ~^r_shift : ^r_shift;
    assign w_take    = r_valid & bus.ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; w_done marks the stop-bit decision cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_fall) w_state_nxt = StStart;
            end
            StStart: begin
                if (w_dec && w_maj) begin
                    w_state_nxt = StIdle;
                end else if (w_end) begin
                    w_state_nxt = StData;
                end
            end
            StData: begin
                if (w_end && (r_idx == 3'd7)) begin
                    w_state_nxt = (PARITY != PARITY_NONE) ? StPar : StStop;
                end
            end
            StPar: begin
                if (w_end) w_state_nxt = StStop;
            end
            StStop: begin
                // Leave at mid-stop so a short stop bit before the next start is tolerated.
                if (w_dec) begin
                    w_state_nxt = StIdle;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Bit timing, sampling, shift register and parity tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_smp     <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (r_state == StIdle || w_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CntS0) r_smp[0] <= w_rx;
            if (r_cnt == CntS1) r_smp[1] <= w_rx;
            if (r_state == StStart) begin
                r_idx <= '0;
            end else if (r_state == StData && w_end) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == StData && w_dec) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
            if (r_state == StIdle) begin
                r_par_err <= 1'b0;
            end else if (r_state == StPar && w_dec) begin
                r_par_err <= (w_maj != w_par_exp);
            end
        end
    end

    // Holding register and sticky overrun; a set beats ovr_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_done && (!r_valid || w_take)) begin
                r_data  <= r_shift;
                r_ferr  <= ~w_maj;
                r_perr  <= r_par_err;
                r_valid <= 1'b1;
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_valid && !bus.ready) begin
                r_ovr <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.valid      = r_valid;
    assign bus.frame_err  = r_ferr;
    assign bus.parity_err = r_perr;
    assign bus.overrun    = r_ovr;
    assign busy           = (r_state != StIdle);
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench: one receiver without parity, one with even parity.
module tb_uart_rx_ovs;
    localparam int unsigned Cpb = 100;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n1;
    logic rx0;
    logic rx1;
    logic busy0;
    logic busy1;

    uart_rx_ovs_if bus0 ();
    uart_rx_ovs_if bus1 ();

    uart_rx_ovs #(.CLKS_PER_BIT(Cpb), .PARITY(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .rx    (rx0),
        .busy  (busy0),
        .bus   (bus0)
    );

    uart_rx_ovs #(.CLKS_PER_BIT(Cpb), .PARITY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .rx    (rx1),
        .busy  (busy1),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         n_acc0 = 0;
    int         n_vcyc0 = 0;
    logic [7:0] acc_data0 = '0;
    logic       acc_ferr0 = 1'b0;
    int         n_acc1 = 0;
    int         n_vcyc1 = 0;
    logic [7:0] acc_data1 = '0;
    logic       acc_perr1 = 1'b0;

    // Transfer monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (bus0.valid) n_vcyc0 <= n_vcyc0 + 1;
        if (bus0.valid && bus0.ready) begin
            n_acc0    <= n_acc0 + 1;
            acc_data0 <= bus0.data_out;
            acc_ferr0 <= bus0.frame_err;
        end
        if (bus1.valid) n_vcyc1 <= n_vcyc1 + 1;
        if (bus1.valid && bus1.ready) begin
            n_acc1    <= n_acc1 + 1;
            acc_data1 <= bus1.data_out;
            acc_perr1 <= bus1.parity_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // 8N1 frame on rx0 with adjustable stop length/level; rx0 is left at the stop level.
    task automatic tx0(input logic [7:0] b, input int stop_clks, input logic stop_v);
        rx0 = 1'b0;
        ticks(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx0 = b[i];
            ticks(Cpb);
        end
        rx0 = stop_v;
        ticks(stop_clks);
    endtask

    // 8E1 frame on rx1 with an explicit parity bit.
    task automatic tx1(input logic [7:0] b, input logic par);
        rx1 = 1'b0;
        ticks(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx1 = b[i];
            ticks(Cpb);
        end
        rx1 = par;
        ticks(Cpb);
        rx1 = 1'b1;
        ticks(Cpb);
    endtask

    initial begin
        int a0;
        int v0;
        int a1;
        int v1;
        int k;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        bus0.ready = 1'b1;
        bus0.ovr_clr = 1'b0;
        bus1.ready = 1'b1;
        bus1.ovr_clr = 1'b0;
        ticks(3);

        check_eq("rst_data", 32'(bus0.data_out), 32'h00);
        check_eq("rst_valid", 32'(bus0.valid), 32'h0);
        check_eq("rst_ferr", 32'(bus0.frame_err), 32'h0);
        check_eq("rst_perr", 32'(bus0.parity_err), 32'h0);
        check_eq("rst_ovr", 32'(bus0.overrun), 32'h0);
        check_eq("rst_busy", 32'(busy0), 32'h0);

        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        ticks(10);

        // 1: single byte, single valid cycle with ready held high.
        a0 = n_acc0;
        v0 = n_vcyc0;
        tx0(8'hAA, Cpb, 1'b1);
        ticks(20);
        check_eq("t1_count", 32'(n_acc0 - a0), 32'd1);
        check_eq("t1_vcycles", 32'(n_vcyc0 - v0), 32'd1);
        check_eq("t1_data", 32'(acc_data0), 32'hAA);
        check_eq("t1_ferr", 32'(acc_ferr0), 32'h0);
        check_eq("t1_ovr", 32'(bus0.overrun), 32'h0);
        check_eq("t1_valid_low", 32'(bus0.valid), 32'h0);

        // 2: back-to-back with a 60-clock stop bit on the first frame.
        a0 = n_acc0;
        tx0(8'h55, 60, 1'b1);
        check_eq("t2_first", 32'(acc_data0), 32'h55);
        tx0(8'hC3, Cpb, 1'b1);
        ticks(20);
        check_eq("t2_count", 32'(n_acc0 - a0), 32'd2);
        check_eq("t2_second", 32'(acc_data0), 32'hC3);
        check_eq("t2_ferr", 32'(acc_ferr0), 32'h0);
        check_eq("t2_ovr", 32'(bus0.overrun), 32'h0);

        // 3: 20-clock glitch is rejected at mid-start.
        a0 = n_acc0;
        rx0 = 1'b0;
        ticks(10);
        check_eq("t3_busy_hi", 32'(busy0), 32'h1);
        ticks(10);
        rx0 = 1'b1;
        k = 0;
        while (busy0 && k < 55) begin
            tick();
            k++;
        end
        check_eq("t3_busy_clr", 32'(busy0), 32'h0);
        ticks(200);
        check_eq("t3_no_valid", 32'(n_acc0 - a0), 32'd0);

        // 4: stop bit low, line stays low; byte delivered with frame_err, no re-arm.
        a0 = n_acc0;
        tx0(8'h3C, Cpb, 1'b0);
        ticks(300);
        check_eq("t4_count", 32'(n_acc0 - a0), 32'd1);
        check_eq("t4_data", 32'(acc_data0), 32'h3C);
        check_eq("t4_ferr", 32'(acc_ferr0), 32'h1);
        check_eq("t4_busy_break", 32'(busy0), 32'h0);
        rx0 = 1'b1;
        ticks(20);
        check_eq("t4_busy_rise", 32'(busy0), 32'h0);
        check_eq("t4_no_new", 32'(n_acc0 - a0), 32'd1);
        tx0(8'h81, Cpb, 1'b1);
        ticks(20);
        check_eq("t4_rearm_data", 32'(acc_data0), 32'h81);
        check_eq("t4_rearm_ferr", 32'(acc_ferr0), 32'h0);

        // 5: consumer stalled; second byte dropped and overrun set.
        bus0.ready = 1'b0;
        a0 = n_acc0;
        tx0(8'h11, Cpb, 1'b1);
        tx0(8'h22, Cpb, 1'b1);
        ticks(20);
        check_eq("t5_valid", 32'(bus0.valid), 32'h1);
        check_eq("t5_held", 32'(bus0.data_out), 32'h11);
        check_eq("t5_ovr", 32'(bus0.overrun), 32'h1);
        bus0.ready = 1'b1;
        tick();
        check_eq("t5_acc_count", 32'(n_acc0 - a0), 32'd1);
        check_eq("t5_acc_data", 32'(acc_data0), 32'h11);
        check_eq("t5_valid_low", 32'(bus0.valid), 32'h0);
        check_eq("t5_ovr_sticky", 32'(bus0.overrun), 32'h1);
        bus0.ovr_clr = 1'b1;
        tick();
        bus0.ovr_clr = 1'b0;
        tick();
        check_eq("t5_ovr_clr", 32'(bus0.overrun), 32'h0);

        // 6: even parity; correct then wrong parity bit, then reset mid-frame.
        a1 = n_acc1;
        tx1(8'h07, 1'b1);
        ticks(20);
        check_eq("t6_good_data", 32'(acc_data1), 32'h07);
        check_eq("t6_good_perr", 32'(acc_perr1), 32'h0);
        tx1(8'h07, 1'b0);
        ticks(20);
        check_eq("t6_bad_count", 32'(n_acc1 - a1), 32'd2);
        check_eq("t6_bad_data", 32'(acc_data1), 32'h07);
        check_eq("t6_bad_perr", 32'(acc_perr1), 32'h1);

        rx1 = 1'b0;
        ticks(Cpb);
        for (int i = 0; i < 3; i++) begin
            rx1 = (i == 1);
            ticks(Cpb);
        end
        rx1 = 1'b1;
        ticks(Cpb / 2);
        check_eq("t6_busy_mid", 32'(busy1), 32'h1);
        rst_n1 = 1'b0;
        tick();
        check_eq("t6_rst_data", 32'(bus1.data_out), 32'h00);
        check_eq("t6_rst_valid", 32'(bus1.valid), 32'h0);
        check_eq("t6_rst_perr", 32'(bus1.parity_err), 32'h0);
        check_eq("t6_rst_ferr", 32'(bus1.frame_err), 32'h0);
        check_eq("t6_rst_ovr", 32'(bus1.overrun), 32'h0);
        check_eq("t6_rst_busy", 32'(busy1), 32'h0);
        a1 = n_acc1;
        v1 = n_vcyc1;
        ticks(3);
        rst_n1 = 1'b1;
        ticks(1200);
        check_eq("t6_no_valid", 32'(n_vcyc1 - v1), 32'd0);
        check_eq("t6_no_acc", 32'(n_acc1 - a1), 32'd0);
        check_eq("t6_idle", 32'(busy1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
